// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a one-entry hold
// buffer for stalls, and branch redirect honouring a single delay slot.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h00400000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] AltPC_IN,
    input  logic        AltPCEnable_IN,
    input  logic        Stall_IN,
    input  logic [31:0] IMemReadData_IN,
    input  logic        IMemReadValid_IN,
    output logic [31:0] IMemReadAddress_OUT,
    output logic        IMemReadRequest_OUT,
    output logic [31:0] Instruction_OUT,
    output logic [31:0] InstructionAddressPlus4_OUT,
    output logic        InstructionValid_OUT
);

    // START: one idle cycle after reset | FETCH: request at PC | HOLD: word buffered during stall
    typedef enum logic [1:0] {START, FETCH, HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_pc4, w_pc4_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_pend_valid, w_pend_valid_nxt;
    logic [31:0] r_pend_target, w_pend_target_nxt;
    logic [31:0] r_hold_instr, w_hold_instr_nxt;
    logic [31:0] r_hold_pc4, w_hold_pc4_nxt;

    logic        w_complete;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_target   = AltPC_IN & 32'hFFFF_FFFC;
    assign w_complete = (r_state == FETCH) && IMemReadValid_IN;
    assign w_redirect = AltPCEnable_IN && r_valid && !Stall_IN;
    // A redirect accepted this cycle beats an older pending one.
    assign w_next_pc  = w_redirect   ? w_target      :
                        r_pend_valid ? r_pend_target : w_pc_plus4;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_pc4_nxt         = r_pc4;
        w_valid_nxt       = r_valid;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        w_hold_instr_nxt  = r_hold_instr;
        w_hold_pc4_nxt    = r_hold_pc4;

        case (r_state)
            START: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (w_complete) begin
                    w_pc_nxt         = w_next_pc;
                    w_pend_valid_nxt = 1'b0;
                    if (Stall_IN) begin
                        w_hold_instr_nxt = IMemReadData_IN;
                        w_hold_pc4_nxt   = w_pc_plus4;
                        w_state_nxt      = HOLD;
                    end else begin
                        w_instr_nxt = IMemReadData_IN;
                        w_pc4_nxt   = w_pc_plus4;
                        w_valid_nxt = 1'b1;
                    end
                end else begin
                    if (!Stall_IN) begin
                        w_valid_nxt = 1'b0;
                    end
                    if (w_redirect) begin
                        w_pend_valid_nxt  = 1'b1;
                        w_pend_target_nxt = w_target;
                    end
                end
            end
            HOLD: begin
                if (!Stall_IN) begin
                    w_instr_nxt = r_hold_instr;
                    w_pc4_nxt   = r_hold_pc4;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = FETCH;
                    // Delay slot already buffered: PC jumps straight to the target.
                    if (w_redirect) begin
                        w_pc_nxt         = w_target;
                        w_pend_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = START;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state       <= START;
            r_pc          <= RESET_VECTOR;
            r_instr       <= 32'd0;
            r_pc4         <= 32'd0;
            r_valid       <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
            r_hold_instr  <= 32'd0;
            r_hold_pc4    <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_pc4         <= w_pc4_nxt;
            r_valid       <= w_valid_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_hold_instr  <= w_hold_instr_nxt;
            r_hold_pc4    <= w_hold_pc4_nxt;
        end
    end

    assign IMemReadAddress_OUT         = r_pc;
    assign IMemReadRequest_OUT         = (r_state == FETCH);
    assign Instruction_OUT             = r_instr;
    assign InstructionAddressPlus4_OUT = r_pc4;
    assign InstructionValid_OUT        = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns ~address so every
// delivered word identifies the address it was fetched from.
module tb_fetch_stage;

    localparam logic [31:0] RV = 32'h00400000;
    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [31:0] Z  = 32'h0;

    // One row: inputs applied before an edge, outputs expected after it.
    typedef struct packed {
        logic        mv;
        logic        st;
        logic        ae;
        logic [31:0] apc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] p4;
    } step_t;

    logic        CLOCK;
    logic        RESET;
    logic [31:0] AltPC_IN;
    logic        AltPCEnable_IN;
    logic        Stall_IN;
    logic [31:0] IMemReadData_IN;
    logic        IMemReadValid_IN;
    logic [31:0] IMemReadAddress_OUT;
    logic        IMemReadRequest_OUT;
    logic [31:0] Instruction_OUT;
    logic [31:0] InstructionAddressPlus4_OUT;
    logic        InstructionValid_OUT;
    logic        mem_valid;

    int total = 0;
    int bad   = 0;

    fetch_stage #(.RESET_VECTOR(RV)) dut (
        .CLOCK                       (CLOCK),
        .RESET                       (RESET),
        .AltPC_IN                    (AltPC_IN),
        .AltPCEnable_IN              (AltPCEnable_IN),
        .Stall_IN                    (Stall_IN),
        .IMemReadData_IN             (IMemReadData_IN),
        .IMemReadValid_IN            (IMemReadValid_IN),
        .IMemReadAddress_OUT         (IMemReadAddress_OUT),
        .IMemReadRequest_OUT         (IMemReadRequest_OUT),
        .Instruction_OUT             (Instruction_OUT),
        .InstructionAddressPlus4_OUT (InstructionAddressPlus4_OUT),
        .InstructionValid_OUT        (InstructionValid_OUT)
    );

    assign IMemReadData_IN  = ~IMemReadAddress_OUT;
    assign IMemReadValid_IN = mem_valid;

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic apply(input step_t s);
        mem_valid      = s.mv;
        Stall_IN       = s.st;
        AltPCEnable_IN = s.ae;
        AltPC_IN       = s.apc;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET          = 1'b1;
        mem_valid      = 1'b0;
        Stall_IN       = 1'b0;
        AltPCEnable_IN = 1'b0;
        AltPC_IN       = 32'h0;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        RESET = 1'b1;
        @(posedge CLOCK);
        #1;
        total++;
        if ({IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, InstructionAddressPlus4_OUT, Instruction_OUT} !== {L, RV, L, Z, Z}) begin
            bad++;
            $display("FAIL reset_state got req=%b addr=%h vld=%b p4=%h ins=%h exp 0/%h/0/0/0",
                     IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, InstructionAddressPlus4_OUT, Instruction_OUT, RV);
        end
        RESET     = 1'b0;
        mem_valid = 1'b1;
        #1;
        total++;
        if ({IMemReadRequest_OUT, IMemReadAddress_OUT} !== {L, RV}) begin
            bad++;
            $display("FAIL reset_start got req=%b addr=%h exp 0/%h", IMemReadRequest_OUT, IMemReadAddress_OUT, RV);
        end
    endtask

    task automatic test_sequential();
        step_t t [4] = '{
            '{H, L, L, Z, H, RV,           L, Z},
            '{H, L, L, Z, H, 32'h00400004, H, 32'h00400004},
            '{H, L, L, Z, H, 32'h00400008, H, 32'h00400008},
            '{H, L, L, Z, H, 32'h0040000C, H, 32'h0040000C}
        };
        do_reset();
        for (int k = 0; k < 4; k++) begin
            apply(t[k]);
            total++;
            if ({IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT} !== {t[k].req, t[k].addr, t[k].vld}) begin
                bad++;
                $display("FAIL seq[%0d] req/addr/vld got=%b/%h/%b exp=%b/%h/%b", k,
                         IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, t[k].req, t[k].addr, t[k].vld);
            end
            if (t[k].vld) begin
                total++;
                if ({InstructionAddressPlus4_OUT, Instruction_OUT} !== {t[k].p4, ~(t[k].p4 - 32'd4)}) begin
                    bad++;
                    $display("FAIL seq[%0d] p4/ins got=%h/%h exp=%h/%h", k,
                             InstructionAddressPlus4_OUT, Instruction_OUT, t[k].p4, ~(t[k].p4 - 32'd4));
                end
            end
        end
    endtask

    task automatic test_wait_states();
        step_t t [7] = '{
            '{L, L, L, Z, H, RV,           L, Z},
            '{L, L, L, Z, H, RV,           L, Z},
            '{L, L, L, Z, H, RV,           L, Z},
            '{H, L, L, Z, H, 32'h00400004, H, 32'h00400004},
            '{L, L, L, Z, H, 32'h00400004, L, Z},
            '{H, L, L, Z, H, 32'h00400008, H, 32'h00400008},
            '{H, L, L, Z, H, 32'h0040000C, H, 32'h0040000C}
        };
        do_reset();
        for (int k = 0; k < 7; k++) begin
            apply(t[k]);
            total++;
            if ({IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT} !== {t[k].req, t[k].addr, t[k].vld}) begin
                bad++;
                $display("FAIL wait[%0d] req/addr/vld got=%b/%h/%b exp=%b/%h/%b", k,
                         IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, t[k].req, t[k].addr, t[k].vld);
            end
            if (t[k].vld) begin
                total++;
                if ({InstructionAddressPlus4_OUT, Instruction_OUT} !== {t[k].p4, ~(t[k].p4 - 32'd4)}) begin
                    bad++;
                    $display("FAIL wait[%0d] p4/ins got=%h/%h exp=%h/%h", k,
                             InstructionAddressPlus4_OUT, Instruction_OUT, t[k].p4, ~(t[k].p4 - 32'd4));
                end
            end
        end
    endtask

    // Branch at 0x00400010 in ID while its delay slot completes the same cycle.
    task automatic test_branch_direct();
        step_t t [9] = '{
            '{H, L, L, Z,            H, RV,           L, Z},
            '{H, L, L, Z,            H, 32'h00400004, H, 32'h00400004},
            '{H, L, L, Z,            H, 32'h00400008, H, 32'h00400008},
            '{H, L, L, Z,            H, 32'h0040000C, H, 32'h0040000C},
            '{H, L, L, Z,            H, 32'h00400010, H, 32'h00400010},
            '{H, L, L, Z,            H, 32'h00400014, H, 32'h00400014},
            '{H, L, H, 32'h00400103, H, 32'h00400100, H, 32'h00400018},
            '{H, L, L, Z,            H, 32'h00400104, H, 32'h00400104},
            '{H, L, L, Z,            H, 32'h00400108, H, 32'h00400108}
        };
        do_reset();
        for (int k = 0; k < 9; k++) begin
            apply(t[k]);
            total++;
            if ({IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT} !== {t[k].req, t[k].addr, t[k].vld}) begin
                bad++;
                $display("FAIL branch[%0d] req/addr/vld got=%b/%h/%b exp=%b/%h/%b", k,
                         IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, t[k].req, t[k].addr, t[k].vld);
            end
            if (t[k].vld) begin
                total++;
                if ({InstructionAddressPlus4_OUT, Instruction_OUT} !== {t[k].p4, ~(t[k].p4 - 32'd4)}) begin
                    bad++;
                    $display("FAIL branch[%0d] p4/ins got=%h/%h exp=%h/%h", k,
                             InstructionAddressPlus4_OUT, Instruction_OUT, t[k].p4, ~(t[k].p4 - 32'd4));
                end
            end
        end
    endtask

    // Delay slot still waiting on memory: target parked as pending; a second
    // enable during the bubble must be ignored.
    task automatic test_branch_pending();
        step_t t [11] = '{
            '{H, L, L, Z,            H, RV,           L, Z},
            '{H, L, L, Z,            H, 32'h00400004, H, 32'h00400004},
            '{H, L, L, Z,            H, 32'h00400008, H, 32'h00400008},
            '{H, L, L, Z,            H, 32'h0040000C, H, 32'h0040000C},
            '{H, L, L, Z,            H, 32'h00400010, H, 32'h00400010},
            '{H, L, L, Z,            H, 32'h00400014, H, 32'h00400014},
            '{L, L, H, 32'h00400202, H, 32'h00400014, L, Z},
            '{L, L, H, 32'h00400500, H, 32'h00400014, L, Z},
            '{H, L, L, Z,            H, 32'h00400200, H, 32'h00400018},
            '{H, L, L, Z,            H, 32'h00400204, H, 32'h00400204},
            '{H, L, L, Z,            H, 32'h00400208, H, 32'h00400208}
        };
        do_reset();
        for (int k = 0; k < 11; k++) begin
            apply(t[k]);
            total++;
            if ({IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT} !== {t[k].req, t[k].addr, t[k].vld}) begin
                bad++;
                $display("FAIL pending[%0d] req/addr/vld got=%b/%h/%b exp=%b/%h/%b", k,
                         IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, t[k].req, t[k].addr, t[k].vld);
            end
            if (t[k].vld) begin
                total++;
                if ({InstructionAddressPlus4_OUT, Instruction_OUT} !== {t[k].p4, ~(t[k].p4 - 32'd4)}) begin
                    bad++;
                    $display("FAIL pending[%0d] p4/ins got=%h/%h exp=%h/%h", k,
                             InstructionAddressPlus4_OUT, Instruction_OUT, t[k].p4, ~(t[k].p4 - 32'd4));
                end
            end
        end
    endtask

    // Delay slot captured into HOLD by a stall; redirect accepted on stall release.
    task automatic test_branch_hold();
        step_t t [11] = '{
            '{H, L, L, Z,            H, RV,           L, Z},
            '{H, L, L, Z,            H, 32'h00400004, H, 32'h00400004},
            '{H, L, L, Z,            H, 32'h00400008, H, 32'h00400008},
            '{H, L, L, Z,            H, 32'h0040000C, H, 32'h0040000C},
            '{H, L, L, Z,            H, 32'h00400010, H, 32'h00400010},
            '{H, L, L, Z,            H, 32'h00400014, H, 32'h00400014},
            '{H, H, H, 32'h00400301, L, 32'h00400018, H, 32'h00400014},
            '{H, H, H, 32'h00400301, L, 32'h00400018, H, 32'h00400014},
            '{H, L, H, 32'h00400301, H, 32'h00400300, H, 32'h00400018},
            '{H, L, L, Z,            H, 32'h00400304, H, 32'h00400304},
            '{H, L, L, Z,            H, 32'h00400308, H, 32'h00400308}
        };
        do_reset();
        for (int k = 0; k < 11; k++) begin
            apply(t[k]);
            total++;
            if ({IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT} !== {t[k].req, t[k].addr, t[k].vld}) begin
                bad++;
                $display("FAIL holdbr[%0d] req/addr/vld got=%b/%h/%b exp=%b/%h/%b", k,
                         IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, t[k].req, t[k].addr, t[k].vld);
            end
            if (t[k].vld) begin
                total++;
                if ({InstructionAddressPlus4_OUT, Instruction_OUT} !== {t[k].p4, ~(t[k].p4 - 32'd4)}) begin
                    bad++;
                    $display("FAIL holdbr[%0d] p4/ins got=%h/%h exp=%h/%h", k,
                             InstructionAddressPlus4_OUT, Instruction_OUT, t[k].p4, ~(t[k].p4 - 32'd4));
                end
            end
        end
    endtask

    task automatic test_stall();
        step_t t [9] = '{
            '{H, L, L, Z, H, RV,           L, Z},
            '{H, L, L, Z, H, 32'h00400004, H, 32'h00400004},
            '{H, H, L, Z, L, 32'h00400008, H, 32'h00400004},
            '{H, H, L, Z, L, 32'h00400008, H, 32'h00400004},
            '{H, H, L, Z, L, 32'h00400008, H, 32'h00400004},
            '{H, H, L, Z, L, 32'h00400008, H, 32'h00400004},
            '{H, L, L, Z, H, 32'h00400008, H, 32'h00400008},
            '{H, L, L, Z, H, 32'h0040000C, H, 32'h0040000C},
            '{H, L, L, Z, H, 32'h00400010, H, 32'h00400010}
        };
        do_reset();
        for (int k = 0; k < 9; k++) begin
            apply(t[k]);
            total++;
            if ({IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT} !== {t[k].req, t[k].addr, t[k].vld}) begin
                bad++;
                $display("FAIL stall[%0d] req/addr/vld got=%b/%h/%b exp=%b/%h/%b", k,
                         IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, t[k].req, t[k].addr, t[k].vld);
            end
            if (t[k].vld) begin
                total++;
                if ({InstructionAddressPlus4_OUT, Instruction_OUT} !== {t[k].p4, ~(t[k].p4 - 32'd4)}) begin
                    bad++;
                    $display("FAIL stall[%0d] p4/ins got=%h/%h exp=%h/%h", k,
                             InstructionAddressPlus4_OUT, Instruction_OUT, t[k].p4, ~(t[k].p4 - 32'd4));
                end
            end
        end
    endtask

    // Redirect to 0xFFFFFFF8 so the PC walks across the 2^32 boundary.
    task automatic test_wrap();
        step_t t [6] = '{
            '{H, L, L, Z,            H, RV,           L, Z},
            '{H, L, L, Z,            H, 32'h00400004, H, 32'h00400004},
            '{H, L, H, 32'hFFFFFFF8, H, 32'hFFFFFFF8, H, 32'h00400008},
            '{H, L, L, Z,            H, 32'hFFFFFFFC, H, 32'hFFFFFFFC},
            '{H, L, L, Z,            H, 32'h00000000, H, 32'h00000000},
            '{H, L, L, Z,            H, 32'h00000004, H, 32'h00000004}
        };
        do_reset();
        for (int k = 0; k < 6; k++) begin
            apply(t[k]);
            total++;
            if ({IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT} !== {t[k].req, t[k].addr, t[k].vld}) begin
                bad++;
                $display("FAIL wrap[%0d] req/addr/vld got=%b/%h/%b exp=%b/%h/%b", k,
                         IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, t[k].req, t[k].addr, t[k].vld);
            end
            if (t[k].vld) begin
                total++;
                if ({InstructionAddressPlus4_OUT, Instruction_OUT} !== {t[k].p4, ~(t[k].p4 - 32'd4)}) begin
                    bad++;
                    $display("FAIL wrap[%0d] p4/ins got=%h/%h exp=%h/%h", k,
                             InstructionAddressPlus4_OUT, Instruction_OUT, t[k].p4, ~(t[k].p4 - 32'd4));
                end
            end
        end
    endtask

    task automatic test_reset_midrequest();
        do_reset();
        apply('{H, L, L, Z, L, Z, L, Z});
        apply('{H, L, L, Z, L, Z, L, Z});
        apply('{L, L, L, Z, L, Z, L, Z});
        RESET = 1'b1;
        #2;
        total++;
        if ({IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, InstructionAddressPlus4_OUT, Instruction_OUT} !== {L, RV, L, Z, Z}) begin
            bad++;
            $display("FAIL async_reset got req=%b addr=%h vld=%b p4=%h ins=%h exp 0/%h/0/0/0",
                     IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, InstructionAddressPlus4_OUT, Instruction_OUT, RV);
        end
        mem_valid = 1'b1;
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        #1;
        total++;
        if ({IMemReadRequest_OUT, IMemReadAddress_OUT} !== {L, RV}) begin
            bad++;
            $display("FAIL late_valid_start got req=%b addr=%h exp 0/%h", IMemReadRequest_OUT, IMemReadAddress_OUT, RV);
        end
        apply('{H, L, L, Z, L, Z, L, Z});
        total++;
        if ({IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT} !== {H, RV, L}) begin
            bad++;
            $display("FAIL late_valid_ignored got req=%b addr=%h vld=%b exp 1/%h/0",
                     IMemReadRequest_OUT, IMemReadAddress_OUT, InstructionValid_OUT, RV);
        end
        apply('{H, L, L, Z, L, Z, L, Z});
        total++;
        if ({InstructionValid_OUT, InstructionAddressPlus4_OUT, Instruction_OUT} !== {H, 32'h00400004, ~RV}) begin
            bad++;
            $display("FAIL restart_first got vld=%b p4=%h ins=%h exp 1/00400004/%h",
                     InstructionValid_OUT, InstructionAddressPlus4_OUT, Instruction_OUT, ~RV);
        end
    endtask

    initial begin
        RESET          = 1'b1;
        mem_valid      = 1'b0;
        Stall_IN       = 1'b0;
        AltPCEnable_IN = 1'b0;
        AltPC_IN       = 32'h0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch_direct();
        test_branch_pending();
        test_branch_hold();
        test_stall();
        test_wrap();
        test_reset_midrequest();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00400000, the first fetch address after reset.
REQ-002 CLOCK  in  1  sole clock; all state updates on its rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 AltPC_IN  in  32  branch/jump target from ID.
REQ-005 AltPCEnable_IN  in  1  ID redirect taken for the instruction currently in ID.
REQ-006 Stall_IN  in  1  hazard hold; while high, ID does not consume the fetch output.
REQ-007 IMemReadData_IN  in  32  instruction word returned by instruction memory.
REQ-008 IMemReadValid_IN  in  1  IMemReadData_IN valid for the current request.
REQ-009 IMemReadAddress_OUT  out  32  fetch address, word aligned.
REQ-010 IMemReadRequest_OUT  out  1  fetch request.
REQ-011 Instruction_OUT  out  32  instruction word to IF/ID.
REQ-012 InstructionAddressPlus4_OUT  out  32  address of Instruction_OUT plus 4.
REQ-013 InstructionValid_OUT  out  1  Instruction_OUT holds a real instruction (0 = bubble).

Function
REQ-014 The FSM SHALL have states START, FETCH and HOLD, with at most one outstanding request.
REQ-015 START SHALL keep IMemReadRequest_OUT low, ignore IMemReadValid_IN, and go to FETCH after one cycle.
REQ-016 FETCH SHALL drive IMemReadRequest_OUT=1 and IMemReadAddress_OUT=PC, both stable until IMemReadValid_IN=1.
REQ-017 A completion is defined as IMemReadRequest_OUT=1 and IMemReadValid_IN=1 in the same cycle; zero-wait memory SHALL yield one instruction per cycle.
REQ-018 On a completion with Stall_IN=0, the block SHALL load Instruction_OUT=data, InstructionAddressPlus4_OUT=PC+4 and InstructionValid_OUT=1 at the next edge; PC SHALL take the next-PC value and the FSM SHALL stay in FETCH.
REQ-019 On a completion with Stall_IN=1, the block SHALL capture data and PC+4 into a hold buffer, update PC to the next-PC value, enter HOLD and leave the outputs unchanged.
REQ-020 HOLD SHALL drive IMemReadRequest_OUT=0; on the first cycle with Stall_IN=0 it SHALL move the buffer to the outputs with InstructionValid_OUT=1 and return to FETCH.
REQ-021 In FETCH, Stall_IN=0 with no completion SHALL set InstructionValid_OUT=0 (bubble); the other output fields are don't-care.
REQ-022 Stall_IN=1 SHALL hold Instruction_OUT, InstructionAddressPlus4_OUT and InstructionValid_OUT unchanged.
REQ-023 Next-PC SHALL be PC+4 modulo 2^32 (32'hFFFFFFFC wraps to 0), except when a redirect applies under REQ-025/026.
REQ-024 A redirect SHALL be accepted only when AltPCEnable_IN=1, InstructionValid_OUT=1 and Stall_IN=0; otherwise AltPCEnable_IN is ignored.
REQ-025 Delay slot: the instruction fetched after the branch SHALL NOT be squashed; the redirect target SHALL be used as next-PC at the delay-slot completion.
REQ-026 If the delay-slot completion occurs in the same cycle the redirect is accepted, next-PC SHALL be the target directly; otherwise the target SHALL be stored in a pending register and consumed, then cleared, at the next completion.
REQ-027 If the delay-slot instruction is already in the HOLD buffer when the redirect is accepted, PC SHALL be overwritten with the target in that cycle and no pending entry SHALL be kept.
REQ-028 AltPC_IN[1:0] SHALL be forced to 2'b00 whenever the target is stored or used.
REQ-029 A second accepted redirect while one is pending SHALL overwrite the pending target.

Reset
REQ-030 RESET=1 SHALL immediately force: state START, PC=RESET_VECTOR, IMemReadAddress_OUT=RESET_VECTOR, IMemReadRequest_OUT=0, Instruction_OUT=0, InstructionAddressPlus4_OUT=0, InstructionValid_OUT=0, pending cleared, hold buffer cleared.
REQ-031 Reset asserted mid-request SHALL abandon the request; a late IMemReadValid_IN in START SHALL be ignored.

Verification
REQ-032 Reset release, zero-wait memory -> requests at 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; first InstructionValid_OUT=1 two edges after release, with InstructionAddressPlus4_OUT=0x00400004.
REQ-033 Memory valid delayed 3 cycles -> address held constant for 3 cycles; InstructionValid_OUT=0 bubbles; no duplicate or skipped instruction.
REQ-034 Branch at 0x00400010 in ID with AltPCEnable_IN=1, AltPC_IN=0x00400103 -> 0x00400014 (delay slot) delivered, then fetch from 0x00400100.
REQ-035 Stall_IN=1 for 4 cycles while a completion occurs -> outputs frozen, request drops in HOLD; after release the held word is emitted, then the next sequential address is fetched.
REQ-036 PC=0xFFFFFFFC completes -> InstructionAddressPlus4_OUT=0x00000000 and next request at 0x00000000.
REQ-037 RESET pulsed while request is outstanding with a late valid -> outputs cleared, the late valid is ignored, and fetching restarts at RESET_VECTOR.
